fsram_pack_writer: RTL and testbench
====================================

# fsram_pack_writer

Write-side packer for the feature SRAM pair. Accepts one output pixel per handshake (8 bits per output channel) from the conv/post-processing stage. Packs two horizontally adjacent pixels into one 16-bit word per channel: the first pixel goes in `[15:8]` (front) and the second in `[7:0]` (back). Writes the packed words row by row into the selected feature SRAM (FSRAM1 or FSRAM2), producing exactly the layout that the next layer's read-side data processing consumes.

## Interface
Parameters:
- `CHANNEL_OUT`, default 32 (`para.v` value): output channels per pixel.
- `ADDR_W`, default 10: SRAM word-address width.
- `ROW_PIX`, default 14: pixels per row, ≥1, may be odd.
- `ROWS`, default 14: rows per frame, ≥1.

Ports:
- `clk`, in, 1: clock; all state on posedge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: begin frame; sampled only in IDLE.
- `bank_sel`, in, 1: target bank, latched at start; 0 = FSRAM1, 1 = FSRAM2.
- `base_addr`, in, `ADDR_W`: first word address, latched at start.
- `pix_valid`, in, 1: pixel available.
- `pix_ready`, out, 1: block can accept a pixel.
- `pix_data`, in, `CHANNEL_OUT*8`: channel c at `[(c+1)*8-1 -: 8]`.
- `sram_wen1`, out, 1: write strobe for FSRAM1, active-high.
- `sram_wen2`, out, 1: write strobe for FSRAM2, active-high.
- `sram_addr`, out, `ADDR_W`: write address.
- `sram_wdata`, out, `CHANNEL_OUT*16`: channel c word at `[(c+1)*16-1 -: 16]`, front `[15:8]`, back `[7:0]`.
- `busy`, out, 1: high from the cycle after start until done.
- `done`, out, 1: one-cycle pulse after the last write.

## Operation
States:
- IDLE: `pix_ready`=0. If `start`=1, latch `bank_sel` and `base_addr`, clear the counters, and go to FRONT.
- FRONT: `pix_ready`=1. On accept (`pix_valid` & `pix_ready`), store the pixel in the front register.
  - If it is the last pixel of the row and `ROW_PIX` is odd, issue a write with back byte 0x00 and advance the row.
  - Otherwise go to BACK.
- BACK: `pix_ready`=1. On accept, issue a write with the stored front byte and this pixel as the back byte, then advance the column. At row end, advance the row; otherwise return to FRONT.
- After the write that completes row `ROWS-1`, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.

Counters and addressing:
- The column counter counts pixels within a row, 0..`ROW_PIX-1`.
- The row counter counts 0..`ROWS-1`.
- The word address starts at `base_addr` and increments by 1 per write, continuing across rows with no gaps.
- Words per row = ceil(`ROW_PIX`/2); total writes = `ROWS` × ceil(`ROW_PIX`/2).
- The address wraps modulo 2^`ADDR_W`.

Write outputs:
- Exactly one of `sram_wen1`/`sram_wen2` pulses per write, chosen by the latched bank.
- The strobe is high only in the write cycle. `sram_addr` and `sram_wdata` hold their last values otherwise.

Boundaries:
- `start` while not IDLE is ignored.
- `pix_valid` while `pix_ready`=0 is ignored; nothing is consumed.
- Gaps in `pix_valid` stall the block with no state change.
- `rst` asserted mid-frame immediately drops all strobes. The partial word is discarded and the block returns to IDLE.

## Timing
- Reset values: `pix_ready`=0, `sram_wen1`=0, `sram_wen2`=0, `sram_addr`=0, `sram_wdata`=0, `busy`=0, `done`=0, state IDLE.
- The `start` cycle is the IDLE→FRONT edge; `pix_ready` is 1 the next cycle.
- Write latency: the strobe, address and data are registered and appear the cycle after the completing pixel's accept edge.
- Sustained throughput is 1 pixel/cycle with no bubbles between rows.
- `done` is asserted the cycle after the last write strobe. `busy` falls together with `done`.
- A new `start` is accepted the cycle after `done`.

## Configuration
- `FSRAM_PACK_RELU_EN` defined: each 8-bit channel value is treated as signed and clamped to 0x00 if negative, before packing (front and back bytes alike).
- Not defined: bytes are packed unmodified.
- Pad bytes are 0x00 in both builds.

## Test plan
- Even row, FSRAM1: `ROW_PIX`=4, `ROWS`=2, `bank_sel`=0, `base_addr`=0x010, pixels whose channel c value is (pixel#·16 + c).
  - Required: 4 writes on `sram_wen1` at 0x010–0x013.
  - Channel 0 of word 0 = 0x0010, word 1 = 0x2030.
  - `sram_wen2` never asserts; `done` pulses once.
- Odd row, FSRAM2: `ROW_PIX`=3, `ROWS`=2, `bank_sel`=1.
  - Required: 4 writes on `sram_wen2`.
  - Words 1 and 3 have back byte 0x00, with no address gap.
- Backpressure: random `pix_valid` gaps; also `start` pulsed mid-frame.
  - Required: write sequence identical to the gap-free run; the mid-frame `start` is ignored.
- Reset mid-frame: assert `rst` after 5 of 8 pixels.
  - Required: strobes drop in the same cycle and all outputs return to reset values.
  - A new frame from `base_addr`=0 then starts its writes at address 0.
- Wrap: `ADDR_W`=4, `base_addr`=0xE, 4 words.
  - Required: addresses 0xE, 0xF, 0x0, 0x1.
- Macro: `FSRAM_PACK_RELU_EN` defined, pixel pair 0x85 then 0x7F.
  - Required: word 0x007F.
  - Without the macro the same input gives 0x857F.

Source files
------------

// File: rtl/fsram_pack_writer_if.sv
// Pixel handshake and feature-SRAM write bus for fsram_pack_writer.
// master: pixel producer / SRAM-side observer. slave: the packer itself.
interface fsram_pack_writer_if #(
  parameter int CHANNEL_OUT = 32,
  parameter int ADDR_W      = 10
);
  logic                      pix_valid;
  logic                      pix_ready;
  logic [CHANNEL_OUT*8-1:0]  pix_data;
  logic                      sram_wen1;
  logic                      sram_wen2;
  logic [ADDR_W-1:0]         sram_addr;
  logic [CHANNEL_OUT*16-1:0] sram_wdata;

  modport master (
    output pix_valid, pix_data,
    input  pix_ready, sram_wen1, sram_wen2, sram_addr, sram_wdata
  );

  modport slave (
    input  pix_valid, pix_data,
    output pix_ready, sram_wen1, sram_wen2, sram_addr, sram_wdata
  );
endinterface

// File: rtl/fsram_pack_writer.sv
// Write-side packer for the feature SRAM pair. Two horizontally adjacent
// pixels are packed per channel into a 16-bit word (front [15:8], back [7:0])
// and written row by row, contiguously from base_addr, into FSRAM1 or FSRAM2.
// Odd-length rows end with a pad byte of 0x00.
// Optional build macro FSRAM_PACK_RELU_EN: clamp negative (signed) channel
// bytes to 0x00 before packing.
module fsram_pack_writer #(
  parameter int CHANNEL_OUT = 32,
  parameter int ADDR_W      = 10,
  parameter int ROW_PIX     = 14,
  parameter int ROWS        = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bank_sel,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  fsram_pack_writer_if.slave bus
);

  localparam int PIX_W  = CHANNEL_OUT * 8;
  localparam int WORD_W = CHANNEL_OUT * 16;
  localparam int COL_W  = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_PIX - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  // FLUSH is the cycle the final write strobe is on the bus, so that done
  // lands one cycle after it.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FRONT,
    S_BACK,
    S_FLUSH,
    S_DONE
  } state_t;

  // Optional ReLU on every channel byte of one pixel.
  function automatic logic [PIX_W-1:0] clamp_pix(input logic [PIX_W-1:0] p);
    logic [PIX_W-1:0] r;
    r = p;
`ifdef FSRAM_PACK_RELU_EN
    for (int c = 0; c < CHANNEL_OUT; c++) begin
      if (p[c*8+7]) r[c*8 +: 8] = 8'h00;
    end
`endif
    return r;
  endfunction

  // Interleave front and back pixels into per-channel 16-bit words.
  function automatic logic [WORD_W-1:0] pack_word(input logic [PIX_W-1:0] f,
                                                  input logic [PIX_W-1:0] b);
    logic [WORD_W-1:0] w;
    for (int c = 0; c < CHANNEL_OUT; c++) begin
      w[c*16 +: 16] = {f[c*8 +: 8], b[c*8 +: 8]};
    end
    return w;
  endfunction

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                bank_q, bank_d;
  logic [PIX_W-1:0]    front_q, front_d;
  logic                wen1_q, wen1_d;
  logic                wen2_q, wen2_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [WORD_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic                pix_ready_q, pix_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept;
  logic                wr;
  logic                row_end;
  logic [WORD_W-1:0]   wr_data;

  assign accept = bus.pix_valid & pix_ready_q;

  // Next-state, counter and write-port computation.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    bank_d       = bank_q;
    front_d      = front_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    wen1_d       = 1'b0;
    wen2_d       = 1'b0;
    wr           = 1'b0;
    row_end      = 1'b0;
    wr_data      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bank_d  = bank_sel;
          addr_d  = base_addr;
          col_d   = '0;
          row_d   = '0;
          front_d = '0;
          state_d = S_FRONT;
        end
      end
      S_FRONT: begin
        if (accept) begin
          if (col_q == LAST_COL) begin
            // Only reachable for odd ROW_PIX: lone pixel, pad the back byte.
            wr      = 1'b1;
            wr_data = pack_word(clamp_pix(bus.pix_data), '0);
            row_end = 1'b1;
          end else begin
            front_d = clamp_pix(bus.pix_data);
            col_d   = col_q + COL_W'(1);
            state_d = S_BACK;
          end
        end
      end
      S_BACK: begin
        if (accept) begin
          wr      = 1'b1;
          wr_data = pack_word(front_q, clamp_pix(bus.pix_data));
          if (col_q == LAST_COL) begin
            row_end = 1'b1;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = S_FRONT;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (row_end) begin
      col_d = '0;
      if (row_q == LAST_ROW) begin
        state_d = S_FLUSH;
      end else begin
        row_d   = row_q + ROW_W'(1);
        state_d = S_FRONT;
      end
    end

    if (wr) begin
      wen1_d       = ~bank_q;
      wen2_d       = bank_q;
      sram_addr_d  = addr_q;
      sram_wdata_d = wr_data;
      addr_d       = addr_q + ADDR_W'(1);
    end

    pix_ready_d = (state_d == S_FRONT) || (state_d == S_BACK);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State and registered outputs; reset clears everything, including the
  // partially packed front pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      bank_q       <= 1'b0;
      front_q      <= '0;
      wen1_q       <= 1'b0;
      wen2_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      pix_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      bank_q       <= bank_d;
      front_q      <= front_d;
      wen1_q       <= wen1_d;
      wen2_q       <= wen2_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      pix_ready_q  <= pix_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.sram_wen1  = wen1_q;
  assign bus.sram_wen2  = wen2_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_fsram_pack_writer.sv
// Scoreboard bench for fsram_pack_writer: two instances (even 4-pixel rows on
// a 10-bit address, odd 3-pixel rows on a 4-bit address), four channels each.
module tb_fsram_pack_writer;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_e, bank_e, busy_e, done_e;
  logic [9:0] base_e;
  logic       start_o, bank_o, busy_o, done_o;
  logic [3:0] base_o;

  fsram_pack_writer_if #(.CHANNEL_OUT(CH), .ADDR_W(10)) if_e ();
  fsram_pack_writer_if #(.CHANNEL_OUT(CH), .ADDR_W(4))  if_o ();

  fsram_pack_writer #(.CHANNEL_OUT(CH), .ADDR_W(10), .ROW_PIX(4), .ROWS(2)) dut_e (
    .clk(clk), .rst(rst), .start(start_e), .bank_sel(bank_e), .base_addr(base_e),
    .busy(busy_e), .done(done_e), .bus(if_e.slave)
  );

  fsram_pack_writer #(.CHANNEL_OUT(CH), .ADDR_W(4), .ROW_PIX(3), .ROWS(2)) dut_o (
    .clk(clk), .rst(rst), .start(start_o), .bank_sel(bank_o), .base_addr(base_o),
    .busy(busy_o), .done(done_o), .bus(if_o.slave)
  );

  typedef struct {
    logic        bank;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t q_e[$];
  wr_t q_o[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  done_cnt_e = 0;
  int  done_cnt_o = 0;
  logic prev_wr_e = 1'b0;
  logic prev_wr_o = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitor for the even instance: pop one expected write per strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_e.sram_wen1 || if_e.sram_wen2) begin
        if (q_e.size() == 0) fail_now("e_unexpected_write");
        else begin
          wr_t w;
          w = q_e.pop_front();
          check("e_wen1", if_e.sram_wen1, !w.bank);
          check("e_wen2", if_e.sram_wen2, w.bank);
          check("e_addr", if_e.sram_addr, w.addr);
          check("e_data", if_e.sram_wdata, w.data);
        end
      end
      if (done_e) begin
        done_cnt_e++;
        check("e_done_after_last_write", prev_wr_e, 1);
        check("e_queue_empty_at_done", q_e.size(), 0);
        check("e_busy_with_done", busy_e, 1);
      end
      prev_wr_e = if_e.sram_wen1 | if_e.sram_wen2;
    end
  end

  // Monitor for the odd instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_o.sram_wen1 || if_o.sram_wen2) begin
        if (q_o.size() == 0) fail_now("o_unexpected_write");
        else begin
          wr_t w;
          w = q_o.pop_front();
          check("o_wen1", if_o.sram_wen1, !w.bank);
          check("o_wen2", if_o.sram_wen2, w.bank);
          check("o_addr", if_o.sram_addr, w.addr);
          check("o_data", if_o.sram_wdata, w.data);
        end
      end
      if (done_o) begin
        done_cnt_o++;
        check("o_done_after_last_write", prev_wr_o, 1);
        check("o_queue_empty_at_done", q_o.size(), 0);
        check("o_busy_with_done", busy_o, 1);
      end
      prev_wr_o = if_o.sram_wen1 | if_o.sram_wen2;
    end
  end

  function automatic logic rdy(input bit w);
    return w ? if_o.pix_ready : if_e.pix_ready;
  endfunction

  task automatic drive_px(input bit w, input logic v, input logic [31:0] d);
    if (w) begin if_o.pix_valid = v; if_o.pix_data = d; end
    else   begin if_e.pix_valid = v; if_e.pix_data = d; end
  endtask

  task automatic push(input bit w, input logic bank, input logic [15:0] a, input logic [63:0] d);
    wr_t x;
    x.bank = bank; x.addr = a; x.data = d;
    if (w) q_o.push_back(x); else q_e.push_back(x);
  endtask

  // Pixel n carries channel c = n*16 + c.
  function automatic logic [31:0] pix(input int n);
    return {8'(n*16+3), 8'(n*16+2), 8'(n*16+1), 8'(n*16)};
  endfunction

  // Present one pixel after `gap` idle cycles; returns at #1 after its accept edge.
  task automatic send_px(input bit w, input logic [31:0] d, input int gap);
    int budget = 200;
    if (gap > 0 || !rdy(w)) drive_px(w, 1'b0, '0);
    repeat (gap) begin @(posedge clk); #1; end
    while (!rdy(w) && budget > 0) begin @(posedge clk); #1; budget--; end
    if (budget == 0) fail_now("pix_ready_timeout");
    drive_px(w, 1'b1, d);
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input bit w, input logic bank, input logic [9:0] base);
    if (w) begin start_o = 1'b1; bank_o = bank; base_o = base[3:0]; end
    else   begin start_e = 1'b1; bank_e = bank; base_e = base; end
    @(posedge clk); #1;
    start_o = 1'b0; start_e = 1'b0;
    check(w ? "o_ready_after_start" : "e_ready_after_start", rdy(w), 1);
    check(w ? "o_busy_after_start" : "e_busy_after_start", w ? busy_o : busy_e, 1);
  endtask

  task automatic wait_done(input bit w, input int exp_cnt);
    int budget = 100;
    drive_px(w, 1'b0, '0);
    while (!(w ? done_o : done_e) && budget > 0) begin @(posedge clk); #1; budget--; end
    if (budget == 0) fail_now(w ? "o_done_timeout" : "e_done_timeout");
    @(posedge clk); #1;
    check(w ? "o_done_one_cycle" : "e_done_one_cycle", w ? done_o : done_e, 0);
    check(w ? "o_busy_falls" : "e_busy_falls", w ? busy_o : busy_e, 0);
    check(w ? "o_idle_not_ready" : "e_idle_not_ready", rdy(w), 0);
    check(w ? "o_done_count" : "e_done_count", w ? done_cnt_o : done_cnt_e, exp_cnt);
  endtask

  // Even-row words for pixels 0..7 (hand-packed, channel 3 leftmost).
  logic [63:0] even_words [4] = '{64'h0313_0212_0111_0010, 64'h2333_2232_2131_2030,
                                  64'h4353_4252_4151_4050, 64'h6373_6272_6171_6070};

  task automatic run_even(input logic bank, input logic [9:0] base, input int gaps[8],
                          input bit mid_start, input int exp_cnt);
    for (int k = 0; k < 4; k++) push(0, bank, 16'(base + 10'(k)), even_words[k]);
    start_frame(0, bank, base);
    for (int n = 0; n < 8; n++) begin
      if (mid_start && n == 3) begin start_e = 1'b1; bank_e = ~bank; base_e = 10'h2AA; end
      send_px(0, pix(n), gaps[n]);
      start_e = 1'b0;
    end
    wait_done(0, exp_cnt);
  endtask

  int no_gaps[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int bp_gaps[8] = '{0, 2, 1, 0, 3, 0, 1, 2};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] relu_w0;
    rst = 1'b1;
    start_e = 0; bank_e = 0; base_e = '0;
    start_o = 0; bank_o = 0; base_o = '0;
    drive_px(0, 1'b0, '0);
    drive_px(1, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_e_ready", if_e.pix_ready, 0);
    check("rst_e_wen", {if_e.sram_wen1, if_e.sram_wen2}, 0);
    check("rst_e_addr", if_e.sram_addr, 0);
    check("rst_e_wdata", if_e.sram_wdata, 0);
    check("rst_e_busy_done", {busy_e, done_e}, 0);
    check("rst_o_outputs", {if_o.pix_ready, if_o.sram_wen1, if_o.sram_wen2, busy_o, done_o}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // pix_valid while idle must not be consumed.
    drive_px(0, 1'b1, 32'hDEAD_BEEF);
    repeat (3) begin @(posedge clk); #1; check("idle_not_ready", if_e.pix_ready, 0); end
    drive_px(0, 1'b0, '0);

    // Even rows into FSRAM1.
    run_even(1'b0, 10'h010, no_gaps, 1'b0, 1);

    // Odd rows into FSRAM2 with address wrap at 4 bits.
    push(1, 1'b1, 16'hE, 64'h0313_0212_0111_0010);
    push(1, 1'b1, 16'hF, 64'h2300_2200_2100_2000);
    push(1, 1'b1, 16'h0, 64'h3343_3242_3141_3040);
    push(1, 1'b1, 16'h1, 64'h5300_5200_5100_5000);
    start_frame(1, 1'b1, 10'h00E);
    for (int n = 0; n < 6; n++) send_px(1, pix(n), 0);
    wait_done(1, 1);

    // Backpressure gaps plus a start pulse mid-frame.
    run_even(1'b0, 10'h010, bp_gaps, 1'b1, 2);

    // Reset after 5 of 8 pixels: only the first two words are written.
    push(0, 1'b0, 16'h100, even_words[0]);
    push(0, 1'b0, 16'h101, even_words[1]);
    start_frame(0, 1'b0, 10'h100);
    for (int n = 0; n < 5; n++) send_px(0, pix(n), 0);
    drive_px(0, 1'b0, '0);
    rst = 1'b1;
    #1;
    check("mid_rst_wen", {if_e.sram_wen1, if_e.sram_wen2}, 0);
    check("mid_rst_addr", if_e.sram_addr, 0);
    check("mid_rst_wdata", if_e.sram_wdata, 0);
    check("mid_rst_ready_busy_done", {if_e.pix_ready, busy_e, done_e}, 0);
    check("mid_rst_writes_seen", q_e.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_even(1'b0, 10'h000, no_gaps, 1'b0, 3);

    // Signed clamp on a 0x85 / 0x7F pair, FSRAM2, 10-bit wrap.
`ifdef FSRAM_PACK_RELU_EN
    relu_w0 = 64'h007F_007F_007F_007F;
`else
    relu_w0 = 64'h857F_857F_857F_857F;
`endif
    push(0, 1'b1, 16'h3FE, relu_w0);
    push(0, 1'b1, 16'h3FF, even_words[1]);
    push(0, 1'b1, 16'h000, even_words[2]);
    push(0, 1'b1, 16'h001, even_words[3]);
    start_frame(0, 1'b1, 10'h3FE);
    send_px(0, 32'h8585_8585, 0);
    send_px(0, 32'h7F7F_7F7F, 0);
    for (int n = 2; n < 8; n++) send_px(0, pix(n), 0);
    wait_done(0, 4);

    repeat (3) @(posedge clk);
    #1;
    check("final_q_e_empty", q_e.size(), 0);
    check("final_q_o_empty", q_o.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
